// File: rtl/od_buf_bank.sv
// rtl/od_buf_bank.sv - open-drain buffer bank with input glitch filter, global enable and stuck-net readback
module od_buf_bank #(
    parameter int   CHANNELS    = 6,
    parameter int   FILTER      = 2,
    parameter int   STUCK_LIMIT = 15,
    parameter logic OD_VALUE    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] y,
    input  logic [CHANNELS-1:0] y_sense,
    input  logic                clr_stuck,
    output logic [CHANNELS-1:0] stuck,
    output logic                any_stuck
);

    localparam int CMAX = (FILTER > STUCK_LIMIT) ? FILTER : STUCK_LIMIT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] F_LAST = CW'(FILTER - 1);
    localparam logic [CW-1:0] S_LAST = CW'(STUCK_LIMIT - 1);
    localparam logic [CW-1:0] S_SAT  = CW'(STUCK_LIMIT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          st;
        logic [CW-1:0] fcnt;
        logic [CW-1:0] scnt;
        logic          stk;
        logic          released;
        logic          low_seen;
        logic          set_now;

        // State only follows a after FILTER consecutive edges of disagreement.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st   <= 1'b1;
                fcnt <= '0;
            end else if (a[i] == st) begin
                fcnt <= '0;
            end else if (fcnt == F_LAST) begin
                st   <= a[i];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end

        assign y[i]     = (en && !st) ? 1'b0 : OD_VALUE;
        assign released = (y[i] == OD_VALUE);
        assign low_seen = released && (y_sense[i] == ~OD_VALUE);
        assign set_now  = low_seen && (scnt == S_LAST);

        // A set on the same edge as a clear wins; the count restarts either way.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                scnt <= '0;
                stk  <= 1'b0;
            end else if (clr_stuck) begin
                scnt <= '0;
                stk  <= set_now;
            end else begin
                if (set_now) begin
                    stk <= 1'b1;
                end
                if (!low_seen) begin
                    scnt <= '0;
                end else if (scnt != S_SAT) begin
                    scnt <= scnt + 1'b1;
                end
            end
        end

        assign stuck[i] = stk;
    end

    assign any_stuck = |stuck;

endmodule

// File: tb/tb_od_buf_bank.sv
// tb/tb_od_buf_bank.sv - randomized and directed self-checking bench for od_buf_bank
module tb_od_buf_bank;

    localparam int CH = 6;
    localparam int FILTER = 2;
    localparam int SL = 15;

    logic          clk;
    logic          rst;
    logic          en;
    logic [CH-1:0] a;
    logic [CH-1:0] y;
    logic [CH-1:0] y_sense;
    logic          clr_stuck;
    logic [CH-1:0] stuck;
    logic          any_stuck;

    int checks;
    int failures;
    bit cmp_on;

    od_buf_bank #(
        .CHANNELS(CH),
        .FILTER(FILTER),
        .STUCK_LIMIT(SL),
        .OD_VALUE(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .a(a),
        .y(y),
        .y_sense(y_sense),
        .clr_stuck(clr_stuck),
        .stuck(stuck),
        .any_stuck(any_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: state follows a when the last FILTER samples all agree and differ from it;
    // stuck sets when the released-and-low run length reaches exactly SL.
    logic              m_state [CH];
    logic [FILTER-1:0] m_hist  [CH];
    int                m_run   [CH];
    logic              m_stuck [CH];

    always @(posedge clk or negedge rst) begin
        logic [FILTER-1:0] h;
        int                r;
        logic              rel;
        logic              setv;
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_state[i] <= 1'b1;
                m_hist[i]  <= '1;
                m_run[i]   <= 0;
                m_stuck[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                h = {m_hist[i][FILTER-2:0], a[i]};
                m_hist[i] <= h;
                if (h == {FILTER{a[i]}} && a[i] != m_state[i]) m_state[i] <= a[i];
                rel  = !(en && !m_state[i]);
                r    = (rel && !y_sense[i]) ? m_run[i] + 1 : 0;
                setv = (r == SL);
                if (clr_stuck) begin
                    m_run[i]   <= 0;
                    m_stuck[i] <= setv;
                end else begin
                    m_run[i]   <= r;
                    m_stuck[i] <= m_stuck[i] | setv;
                end
            end
        end
    end

    function automatic logic [CH-1:0] exp_y();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (en && !m_state[i]) ? 1'b0 : 1'b1;
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_stuck();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_stuck[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_y", 32'(y), 32'(exp_y()));
            chk("model_stuck", 32'(stuck), 32'(exp_stuck()));
            chk("model_any_stuck", 32'(any_stuck), 32'(|exp_stuck()));
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cmp_on = 1'b0;
        rst = 1'b1;
        en = 1'b1;
        a = '0;
        y_sense = '1;
        clr_stuck = 1'b0;
        #1 rst = 1'b0;
        #1 cmp_on = 1'b1;

        // Reset with a all low
        tick(3);
        chk("reset_y", 32'(y), 32'h3F);
        chk("reset_stuck", 32'(stuck), 32'h0);
        chk("reset_any", 32'(any_stuck), 32'h0);
        rst = 1'b1;
        tick(1);
        chk("filter_edge1_y", 32'(y), 32'h3F);
        tick(1);
        chk("filter_edge2_y", 32'(y), 32'h00);

        // Glitch rejection on channel 0
        a = '1;
        tick(2);
        chk("release_y", 32'(y), 32'h3F);
        a[0] = 1'b0;
        tick(1);
        chk("glitch_y0_a", 32'(y[0]), 32'h1);
        a[0] = 1'b1;
        tick(1);
        chk("glitch_y0_b", 32'(y[0]), 32'h1);
        tick(1);
        chk("glitch_y0_c", 32'(y[0]), 32'h1);
        a[0] = 1'b0;
        tick(1);
        chk("hold_y0_edge1", 32'(y[0]), 32'h1);
        tick(1);
        chk("hold_y0_edge2", 32'(y[0]), 32'h0);

        // Global enable acts in the same cycle
        a = '0;
        tick(2);
        chk("all_low_y", 32'(y), 32'h00);
        en = 1'b0;
        #1 chk("en_off_y", 32'(y), 32'h3F);
        en = 1'b1;
        #1 chk("en_on_y", 32'(y), 32'h00);

        // Stuck detect on channel 2: 14 low edges is not enough
        a = '1;
        tick(2);
        y_sense = 6'h3B;
        tick(14);
        y_sense = '1;
        tick(1);
        chk("stuck_14_short", 32'(stuck), 32'h0);
        y_sense = 6'h3B;
        tick(14);
        chk("stuck_at_14", 32'(stuck), 32'h0);
        tick(1);
        chk("stuck_at_15", 32'(stuck), 32'h4);
        chk("any_stuck_set", 32'(any_stuck), 32'h1);

        // Clear, then clear coincident with a set edge
        y_sense = '1;
        clr_stuck = 1'b1;
        tick(1);
        clr_stuck = 1'b0;
        chk("clear_stuck", 32'(stuck), 32'h0);
        y_sense = 6'h3B;
        tick(14);
        clr_stuck = 1'b1;
        tick(1);
        clr_stuck = 1'b0;
        chk("clear_vs_set", 32'(stuck), 32'h4);
        tick(3);
        chk("sticky_after", 32'(stuck), 32'h4);
        y_sense = '1;
        clr_stuck = 1'b1;
        tick(1);
        clr_stuck = 1'b0;
        chk("clear_again", 32'(stuck), 32'h0);

        // Asynchronous reset in the middle of a count
        y_sense = 6'h3B;
        tick(10);
        #2 rst = 1'b0;
        #1 chk("async_rst_stuck", 32'(stuck), 32'h0);
        rst = 1'b1;
        tick(14);
        chk("recount_14", 32'(stuck), 32'h0);
        tick(1);
        chk("recount_15", 32'(stuck), 32'h4);

        // Randomized traffic with slowly varying inputs
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
                if ($urandom_range(0, 40) == 0) y_sense[i] = ~y_sense[i];
            end
            en = ($urandom_range(0, 19) != 0);
            clr_stuck = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            tick(1);
        end
        clr_stuck = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
